mcp42000_driver: RTL and testbench

SPI write-only driver for a Microchip MCP42xxx dual digital potentiometer. It accepts an 8-bit wiper value and a wiper select over a valid/ready handshake. It then serialises the 16-bit "write data" command to the device over CS/SCK/MOSI using SPI mode 0,0, MSB first. It sits between the acoustics front-end gain/threshold control logic and the physical pot pins.

---
 rtl/mcp42000_driver.sv | 137 +++++++++++++
 tb/tb_mcp42000_driver.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mcp42000_driver.sv
// SPI mode 0,0 write-only driver for the MCP42xxx dual digital potentiometer.
// Define MCP42000_DRIVER_SHDN_EN to add the shdn input (sends the shutdown command).
module mcp42000_driver #(
    parameter int SCK_HALF = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] val,
    input  logic       wiper_sel,
    input  logic       valid,
`ifdef MCP42000_DRIVER_SHDN_EN
    input  logic       shdn,
`endif
    output logic       ready,
    output logic       cs,
    output logic       sck,
    output logic       mosi
);

    localparam int DW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(SCK_HALF - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_END,
        S_GAP
    } state_t;

    state_t          r_state, w_state;
    logic [DW-1:0]   r_div, w_div;
    logic [4:0]      r_half, w_half;
    logic [14:0]     r_shift, w_shift;
    logic            r_cs, w_cs;
    logic            r_sck, w_sck;
    logic            r_mosi, w_mosi;
    logic            r_ready, w_ready;
    logic            w_tick;
    logic [15:0]     w_word;

    // PP bits select the pot: 01 for pot 0, 10 for pot 1.
`ifdef MCP42000_DRIVER_SHDN_EN
    assign w_word = shdn ? {6'b001000, wiper_sel, ~wiper_sel, 8'h00}
                         : {6'b000100, wiper_sel, ~wiper_sel, val};
`else
    assign w_word = {6'b000100, wiper_sel, ~wiper_sel, val};
`endif

    assign w_tick = (r_div == DIV_MAX);

    always_comb begin
        w_state = r_state;
        w_div   = w_tick ? '0 : r_div + 1'b1;
        w_half  = r_half;
        w_shift = r_shift;
        w_cs    = r_cs;
        w_sck   = r_sck;
        w_mosi  = r_mosi;
        w_ready = r_ready;

        case (r_state)
            S_IDLE: begin
                w_div = '0;
                if (valid) begin
                    w_state = S_SHIFT;
                    w_cs    = 1'b0;
                    w_ready = 1'b0;
                    w_sck   = 1'b0;
                    w_half  = 5'd0;
                    w_mosi  = w_word[15];
                    w_shift = w_word[14:0];
                end
            end
            S_SHIFT: begin
                if (w_tick) begin
                    w_sck  = ~r_sck;
                    w_half = r_half + 5'd1;
                    // The 32nd half-period is the 16th falling edge; bit0 stays on mosi.
                    if (r_half == 5'd31) begin
                        w_state = S_END;
                    end else if (r_sck) begin
                        w_mosi  = r_shift[14];
                        w_shift = {r_shift[13:0], 1'b0};
                    end
                end
            end
            S_END: begin
                if (w_tick) begin
                    w_cs    = 1'b1;
                    w_state = S_GAP;
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_state = S_IDLE;
                    w_ready = 1'b1;
                    w_mosi  = 1'b0;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cs    = 1'b1;
                w_sck   = 1'b0;
                w_mosi  = 1'b0;
                w_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_half  <= 5'd0;
            r_shift <= 15'd0;
            r_cs    <= 1'b1;
            r_sck   <= 1'b0;
            r_mosi  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state;
            r_div   <= w_div;
            r_half  <= w_half;
            r_shift <= w_shift;
            r_cs    <= w_cs;
            r_sck   <= w_sck;
            r_mosi  <= w_mosi;
            r_ready <= w_ready;
        end
    end

    assign ready = r_ready;
    assign cs    = r_cs;
    assign sck   = r_sck;
    assign mosi  = r_mosi;

endmodule

// File: tb/tb_mcp42000_driver.sv
// Self-checking bench for mcp42000_driver: frames are decoded from the pins and
// compared against words built from the device command format.
module tb_mcp42000_driver;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] val = 8'h00;
    logic       wiper_sel = 1'b0;
    logic       valid = 1'b0;
    logic       ready, cs, sck, mosi;
`ifdef MCP42000_DRIVER_SHDN_EN
    logic       shdn = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mcp42000_driver #(.SCK_HALF(H)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .val       (val),
        .wiper_sel (wiper_sel),
        .valid     (valid),
`ifdef MCP42000_DRIVER_SHDN_EN
        .shdn      (shdn),
`endif
        .ready     (ready),
        .cs        (cs),
        .sck       (sck),
        .mosi      (mosi)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic waitReady();
        int waitCnt;
        waitCnt = 0;
        while (ready !== 1'b1 && waitCnt < 40 * H) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("readyBeforeAccept", ready, 1);
    endtask

    // One complete frame: accept, then decode the pins for 34H cycles.
    task automatic applyStimulus(input logic [7:0] v, input logic s, input bit hold, input bit scramble);
        logic [15:0] expWord, got;
        int rises, falls, highs;
        bit mosiBad, timeBad, csBad, readyBad;
        logic prevSck, prevMosi;
        expWord = {(s ? 8'h12 : 8'h11), v};
        waitReady();
        val = v;
        wiper_sel = s;
        valid = 1'b1;
        @(negedge clk);
        checkOutput("acceptCs", cs, 0);
        checkOutput("acceptReady", ready, 0);
        checkOutput("acceptSck", sck, 0);
        checkOutput("acceptMosiBit15", mosi, expWord[15]);
        if (!hold) valid = 1'b0;
        got = '0;
        rises = 0; falls = 0; highs = 0;
        mosiBad = 0; timeBad = 0; csBad = 0; readyBad = 0;
        prevSck = sck;
        prevMosi = mosi;
        for (int n = 1; n <= 34 * H; n++) begin
            if (scramble) begin
                val = 8'($urandom);
                wiper_sel = 1'($urandom);
            end
            @(negedge clk);
            if (n < 34 * H) begin
                if (sck === 1'b1) highs++;
                if (prevSck === 1'b0 && sck === 1'b1) begin
                    got = {got[14:0], mosi};
                    if (n != H * (2 * rises + 1)) timeBad = 1;
                    rises++;
                end
                if (prevSck === 1'b1 && sck === 1'b0) begin
                    if (n != H * (2 * falls + 2)) timeBad = 1;
                    falls++;
                end else if (mosi !== prevMosi) begin
                    mosiBad = 1;
                end
                if (n < 33 * H && cs !== 1'b0) csBad = 1;
                if (n >= 33 * H && cs !== 1'b1) csBad = 1;
                if (ready !== 1'b0) readyBad = 1;
            end
            prevSck = sck;
            prevMosi = mosi;
        end
        checkOutput("frameWord", got, expWord);
        checkOutput("sckRises", rises, 16);
        checkOutput("sckFalls", falls, 16);
        checkOutput("sckHighCycles", highs, 16 * H);
        checkOutput("sckEdgeTiming", timeBad, 0);
        checkOutput("mosiOnlyOnFall", mosiBad, 0);
        checkOutput("csWindow", csBad, 0);
        checkOutput("readyLowWhileBusy", readyBad, 0);
        checkOutput("readyAtT34H", ready, 1);
        checkOutput("csIdleAfterFrame", cs, 1);
        checkOutput("mosiIdleAfterFrame", mosi, 0);
        checkOutput("sckIdleAfterFrame", sck, 0);
    endtask

    // Abandon a frame with reset once bit 8 has been clocked out.
    task automatic resetMidFrame(input logic [7:0] v, input logic s);
        waitReady();
        val = v;
        wiper_sel = s;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (16 * H) @(negedge clk);
        checkOutput("midFrameCsLow", cs, 0);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("asyncResetCs", cs, 1);
        checkOutput("asyncResetSck", sck, 0);
        checkOutput("asyncResetMosi", mosi, 0);
        checkOutput("asyncResetReady", ready, 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        $display("[TB] start, SCK_HALF=%0d", H);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetCs", cs, 1);
        checkOutput("resetSck", sck, 0);
        checkOutput("resetMosi", mosi, 0);
        checkOutput("resetReady", ready, 1);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("postResetReady", ready, 1);
        checkOutput("postResetCs", cs, 1);

        applyStimulus(8'd42, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'd73, 1'b1, 1'b0, 1'b0);

        // valid held high: frames run back to back with the idle gap between them
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(8'($urandom), 1'($urandom), 1'b0, 1'b1);
        end

        resetMidFrame(8'hA5, 1'b1);
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
